// File: rtl/sienna_pkg.sv
// Shared types for the feature-map buffer slice.
// Holds the fill FSM state encoding.
package sienna_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } fmap_state_t;

endpackage

// File: rtl/sram_1r1w.sv
// Simple dual-port storage: one write port, one registered read port.
// Read data holds until the next read enable.
module sram_1r1w #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 9,
  parameter int AW         = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fmap_buffer.sv
// Feature-map frame buffer between pooling and the next layer.
// Fills a ROWSxCOLS frame in raster order, then serves random reads.
module fmap_buffer
  import sienna_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int ROWS       = 3,
  parameter  int COLS       = 3,
  localparam int SIZE       = ROWS * COLS,
  localparam int AW         = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  fill_done,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  err_wr,
  output logic                  err_rd
);

  localparam logic [AW:0] SIZE_W = (AW+1)'(SIZE);
  localparam logic [AW:0] LAST   = (AW+1)'(SIZE - 1);

  fmap_state_t state, state_d;
  logic [AW:0] wr_cnt, cnt_d, fill_ptr;
  logic start_q, start_arm, start_edge;
  logic we, wr_err, rd_ok, rd_err, rd_ok_q;
  logic [DATA_WIDTH-1:0] sram_q;

  // start_arm masks the first cycle after reset so a held start is ignored
  assign start_edge = start & ~start_q & start_arm;
  assign fill_ptr   = start_edge ? '0 : wr_cnt;
  assign rd_ok      = (state == ST_READY)
                   && ({1'b0, rd_addr} < SIZE_W);
  assign rd_err     = rd_en & ~rd_ok;
  assign fill_done  = (state == ST_READY);
  assign rd_data    = rd_ok_q ? sram_q : '0;

  always_comb begin
    state_d = state;
    cnt_d   = wr_cnt;
    we      = 1'b0;
    wr_err  = 1'b0;
    unique case (state)
      ST_FILL: begin
        cnt_d = fill_ptr;
        if (wr_valid) begin
          we = 1'b1;
          if (fill_ptr == LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = fill_ptr + 1'b1;
          end
        end
      end
      ST_IDLE, ST_READY: begin
        wr_err = wr_valid;
        if (start_edge) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_cnt    <= '0;
      start_q   <= 1'b0;
      start_arm <= 1'b0;
      rd_valid  <= 1'b0;
      rd_ok_q   <= 1'b0;
      err_wr    <= 1'b0;
      err_rd    <= 1'b0;
    end else begin
      state     <= state_d;
      wr_cnt    <= cnt_d;
      start_q   <= start;
      start_arm <= 1'b1;
      rd_valid  <= rd_en;
      if (rd_en) rd_ok_q <= rd_ok;
      err_wr    <= (err_wr & ~start_edge) | wr_err;
      err_rd    <= (err_rd & ~start_edge) | rd_err;
    end
  end

  sram_1r1w #(
    .DATA_WIDTH(DATA_WIDTH),
    .SIZE      (SIZE),
    .AW        (AW)
  ) u_sram (
    .clk  (clk),
    .we   (we),
    .waddr(fill_ptr[AW-1:0]),
    .wdata(wr_data),
    .re   (rd_en & rd_ok),
    .raddr(rd_addr),
    .rdata(sram_q)
  );

endmodule

// File: tb/tb_fmap_buffer.sv
// Scoreboard bench for fmap_buffer (3x3 frame, 8-bit pixels).
// Reads push expected data; a negedge monitor pops and compares.
module tb_fmap_buffer;

  logic       clk = 1'b0;
  logic       rst_n, start, wr_valid, rd_en;
  logic [7:0] wr_data;
  logic [3:0] rd_addr;
  logic       fill_done, rd_valid, err_wr, err_rd;
  logic [7:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  fmap_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .fill_done(fill_done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .err_wr   (err_wr),
    .err_rd   (err_rd)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr_burst(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
    tick();
    check("rd_valid_drop", rd_valid, 0);
    check("rd_hold", rd_data, e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; start = 0; wr_valid = 0;
    rd_en = 0; wr_data = 0; rd_addr = 0;
    tick(); tick();
    check("rst_fill_done", fill_done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_err_wr", err_wr, 0);
    check("rst_err_rd", err_rd, 0);
    rst_n = 1;
    tick(); tick();

    rd(4'd0, 8'h00);
    check("idle_rd_err", err_rd, 1);

    pulse_start();
    check("start_clr_err_rd", err_rd, 0);
    wr_burst(8'h10, 8);
    check("fill_done_8", fill_done, 0);
    wr_burst(8'h18, 1);
    check("fill_done_9", fill_done, 1);
    check("fill_err_wr", err_wr, 0);
    rd(4'd4, 8'h14);
    rd(4'd8, 8'h18);
    check("good_rd_err", err_rd, 0);
    rd(4'd9, 8'h00);
    check("oob_rd_err", err_rd, 1);
    rd(4'd15, 8'h00);

    wr_burst(8'hFF, 1);
    check("ready_err_wr", err_wr, 1);
    check("ready_hold", fill_done, 1);
    rd(4'd0, 8'h10);

    start   = 1'b1;
    rd_en   = 1'b1;
    rd_addr = 4'd2;
    exp_q.push_back(8'h12);
    tick();
    start = 1'b0;
    rd_en = 1'b0;
    check("leave_fill_done", fill_done, 0);
    check("leave_err_wr", err_wr, 0);
    check("leave_err_rd", err_rd, 0);

    rd(4'd3, 8'h00);
    check("fill_rd_err", err_rd, 1);
    wr_burst(8'h50, 4);
    pulse_start();
    wr_burst(8'hA0, 8);
    check("restart_8", fill_done, 0);
    wr_burst(8'hA8, 1);
    check("restart_9", fill_done, 1);
    check("restart_err_wr", err_wr, 0);
    check("restart_err_rd", err_rd, 0);
    for (int i = 0; i < 9; i++)
      rd(4'(i), 8'hA0 + 8'(i));

    pulse_start();
    wr_burst(8'h60, 3);
    start    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hB0;
    tick();
    start = 1'b0;
    wr_valid = 1'b0;
    wr_burst(8'hB1, 7);
    check("co_start_7", fill_done, 0);
    wr_burst(8'hB8, 1);
    check("co_start_8", fill_done, 1);
    check("co_start_err_wr", err_wr, 0);
    rd(4'd0, 8'hB0);
    rd(4'd3, 8'hB3);
    rd(4'd8, 8'hB8);

    pulse_start();
    wr_burst(8'hC0, 5);
    start = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    check("rst2_fill_done", fill_done, 0);
    check("rst2_rd_valid", rd_valid, 0);
    check("rst2_rd_data", rd_data, 0);
    check("rst2_err_wr", err_wr, 0);
    check("rst2_err_rd", err_rd, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("held_start_idle", fill_done, 0);
    wr_burst(8'h77, 1);
    check("held_start_err_wr", err_wr, 1);
    rd(4'd0, 8'h00);
    check("held_start_err_rd", err_rd, 1);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("toggle_err_wr", err_wr, 0);
    check("toggle_err_rd", err_rd, 0);
    start = 1'b0;
    wr_burst(8'h30, 9);
    check("toggle_fill_done", fill_done, 1);
    rd(4'd1, 8'h31);
    rd(4'd5, 8'h35);

    tick(); tick();
    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
